// File: rtl/ifetch_if.sv
// Instruction-fetch bus: memory read channel toward instruction memory and
// the valid/ready instruction channel toward decode.
interface ifetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;

    modport master (
        output mem_req, mem_addr, ins_valid, ins_data, ins_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, ins_ready
    );
    modport slave (
        input  mem_req, mem_addr, ins_valid, ins_data, ins_pc,
        output mem_gnt, mem_rvalid, mem_rdata, ins_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Sequential instruction fetcher with a credit-limited prefetch queue and
// redirect handling that discards stale in-flight responses.
module ifetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    ifetch_if.master          bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop_cnt;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [DATA_W-1:0] r_ins_data;
    logic [ADDR_W-1:0] r_ins_pc;

    logic [CW:0]       w_occupancy;
    logic              w_req;
    logic              w_grant;
    logic              w_pop;
    logic              w_drop;
    logic              w_push;
    logic [CW-1:0]     w_inflight_nxt;
    logic [CW-1:0]     w_count_left;
    logic [CW-1:0]     w_count_nxt;
    logic [CW-1:0]     w_drop_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Queue entries plus outstanding requests never exceed DEPTH, so every
    // returning word is guaranteed a free slot.
    assign w_occupancy    = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req          = !reset && !redirect_valid && (w_occupancy < L_DEPTH);
    assign w_grant        = w_req && bus.mem_gnt;
    assign w_pop          = (r_count != '0) && bus.ins_ready;
    assign w_drop         = bus.mem_rvalid && (redirect_valid || (r_drop_cnt != '0));
    assign w_push         = bus.mem_rvalid && !w_drop;
    assign w_inflight_nxt = r_inflight + CW'(w_grant) - CW'(bus.mem_rvalid);
    assign w_count_left   = r_count - CW'(w_pop);
    assign w_count_nxt    = redirect_valid ? '0 : (w_count_left + CW'(w_push));
    assign w_rd_ptr_nxt   = r_rd_ptr + PW'(w_pop);
    assign w_redirect_pc  = {redirect_addr[ADDR_W-1:1], 1'b0};

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid)
            w_drop_nxt = w_inflight_nxt;
        else if (bus.mem_rvalid && (r_drop_cnt != '0))
            w_drop_nxt = r_drop_cnt - CW'(1);
    end

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_fetch_pc;
    assign bus.ins_valid = (r_count != '0);
    assign bus.ins_data  = r_ins_data;
    assign bus.ins_pc    = r_ins_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_ins_data <= '0;
            r_ins_pc   <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_grant)
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(2);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + ADDR_W'(2);
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                end
                r_rd_ptr <= w_rd_ptr_nxt;
                // Output registers track the next head; an arriving word that
                // lands in an otherwise empty queue is loaded straight in.
                if (w_count_nxt != '0) begin
                    if (w_count_left == '0) begin
                        r_ins_data <= bus.mem_rdata;
                        r_ins_pc   <= r_resp_pc;
                    end else begin
                        r_ins_data <= r_q_data[w_rd_ptr_nxt];
                        r_ins_pc   <= r_q_pc[w_rd_ptr_nxt];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.mem_rdata;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_rvalid && (r_inflight == '0)));
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model plus an expected-PC stream
// model that restarts at each redirect target.
module tb_ifetch_unit;
    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;

    ifetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ifetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    mreq_t       pending[$];
    logic [15:0] granted[$];
    logic [15:0] delivered[$];
    logic [15:0] exp_pc = RESET_PC;
    logic [15:0] prev_addr = '0;
    logic        prev_stall = 1'b0;
    logic        gnt_on = 1'b1;
    bit          rand_gnt = 1'b0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] qget(input logic [15:0] q[$], input int i);
        if (i < q.size()) return {16'h0, q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive memory, settle, score the cycle, advance to posedge+1.
    task automatic cycle();
        int rsp_now;
        int due;
        rsp_now = 0;
        if (!reset && pending.size() > 0 && pending[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = pending[0].addr ^ 16'hA5A5;
            void'(pending.pop_front());
            rsp_now = 1;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 16'($urandom);
        end
        bus.mem_gnt = rand_gnt ? (($urandom % 3) != 0) : gnt_on;
        #1;
        if (redirect_valid)
            check_eq("no_req_on_redirect", {31'h0, bus.mem_req}, 32'h0);
        if (prev_stall && !redirect_valid && !reset) begin
            check_eq("req_held", {31'h0, bus.mem_req}, 32'h1);
            check_eq("addr_held", {16'h0, bus.mem_addr}, {16'h0, prev_addr});
        end
        prev_stall = bus.mem_req && !bus.mem_gnt;
        prev_addr  = bus.mem_addr;
        if (bus.mem_req && bus.mem_gnt) begin
            check_eq("credit", {31'h0, (pending.size() + rsp_now) < DEPTH}, 32'h1);
            granted.push_back(bus.mem_addr);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{bus.mem_addr, due});
        end
        if (bus.ins_valid && bus.ins_ready) begin
            check_eq("ins_pc", {16'h0, bus.ins_pc}, {16'h0, exp_pc});
            check_eq("ins_data", {16'h0, bus.ins_data}, {16'h0, exp_pc ^ 16'hA5A5});
            delivered.push_back(bus.ins_pc);
            exp_pc = exp_pc + 16'd2;
        end
        if (redirect_valid)
            exp_pc = redirect_addr & 16'hFFFE;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        pending.delete();
        exp_pc     = RESET_PC;
        prev_stall = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int first;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.ins_ready  = 1'b1;

        // Reset values and first-fetch latency with a zero-wait memory.
        @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check_eq("rst_mem_addr", {16'h0, bus.mem_addr}, {16'h0, RESET_PC});
        check_eq("rst_ins_valid", {31'h0, bus.ins_valid}, 32'h0);
        check_eq("rst_ins_data", {16'h0, bus.ins_data}, 32'h0);
        check_eq("rst_ins_pc", {16'h0, bus.ins_pc}, 32'h0);
        cycle();
        reset = 1'b0;
        first = -1;
        for (int k = 0; k < 14; k++) begin
            if (k >= 2) check_eq("t1_stream_valid", {31'h0, bus.ins_valid}, 32'h1);
            if (first < 0 && bus.ins_valid) first = k;
            cycle();
        end
        check_eq("t1_first_valid", first, 2);

        // Decode stalled: exactly DEPTH grants, then resume in order.
        bus.ins_ready = 1'b0;
        do_reset();
        granted.delete();
        run(10);
        check_eq("t2_grants", granted.size(), DEPTH);
        check_eq("t2_req_stalled", {31'h0, bus.mem_req}, 32'h0);
        bus.ins_ready = 1'b1;
        granted.delete();
        delivered.delete();
        run(12);
        check_eq("t2_first_pc", qget(delivered, 0), 32'h0000);
        check_eq("t2_fourth_pc", qget(delivered, 3), 32'h0006);
        check_eq("t2_resume_addr", qget(granted, 0), 32'h0008);

        // Redirect with two slow responses in flight.
        lat = 3;
        do_reset();
        run(2);
        gnt_on         = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0100;
        granted.delete();
        cycle();
        redirect_valid = 1'b0;
        gnt_on         = 1'b1;
        delivered.delete();
        check_eq("t3_queue_empty", {31'h0, bus.ins_valid}, 32'h0);
        run(15);
        check_eq("t3_first_pc", qget(delivered, 0), 32'h0100);
        check_eq("t3_first_grant", qget(granted, 0), 32'h0100);

        // Redirect to an odd address while the head is being accepted.
        lat = 1;
        do_reset();
        run(6);
        check_eq("t4_head_valid", {31'h0, bus.ins_valid}, 32'h1);
        delivered.delete();
        granted.delete();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0203;
        cycle();
        redirect_valid = 1'b0;
        run(8);
        check_eq("t4_head_delivered", qget(delivered, 0), 32'h0008);
        check_eq("t4_after_redirect", qget(delivered, 1), 32'h0202);
        check_eq("t4_first_grant", qget(granted, 0), 32'h0202);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFC;
        cycle();
        redirect_valid = 1'b0;
        delivered.delete();
        run(10);
        check_eq("t5_pc0", qget(delivered, 0), 32'hFFFC);
        check_eq("t5_pc1", qget(delivered, 1), 32'hFFFE);
        check_eq("t5_pc2", qget(delivered, 2), 32'h0000);

        // Reset mid-stream with a full queue.
        bus.ins_ready = 1'b0;
        run(10);
        check_eq("t6_full_valid", {31'h0, bus.ins_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_valid", {31'h0, bus.ins_valid}, 32'h0);
        check_eq("t6_rst_req", {31'h0, bus.mem_req}, 32'h0);
        pending.delete();
        exp_pc     = RESET_PC;
        prev_stall = 1'b0;
        cycle();
        reset         = 1'b0;
        bus.ins_ready = 1'b1;
        granted.delete();
        delivered.delete();
        run(8);
        check_eq("t6_restart_grant", qget(granted, 0), {16'h0, RESET_PC});
        check_eq("t6_restart_pc", qget(delivered, 0), {16'h0, RESET_PC});

        // Random grants, latencies, decode back-pressure and redirects.
        rand_gnt = 1'b1;
        delivered.delete();
        for (int i = 0; i < 3000; i++) begin
            lat            = $urandom_range(1, 4);
            bus.ins_ready  = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 40) == 0;
            redirect_addr  = 16'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;
        check_eq("rand_progress", {31'h0, delivered.size() > 200}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Consumer end of the program-counter/instruction-address interface: issues sequential instruction-word read requests to instruction memory and collects in-order responses.
- Buffers fetched words in a small prefetch queue and presents them, tagged with their PC, to decode over a valid/ready handshake.
- Owns fetch sequencing: +2 per halfword-aligned 16-bit instruction; branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
- ADDR_W, 16, instruction address width.
- DATA_W, 16, instruction word width.
- DEPTH, 4, prefetch queue entries; power of 2, >=2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- redirect_valid  input  1  branch/jump taken; pulse for one cycle.
- redirect_addr  input  ADDR_W  new fetch target; bit 0 ignored (treated as 0).
- mem_req  output  1  read request valid.
- mem_addr  output  ADDR_W  read address.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
- mem_rdata  input  DATA_W  read data.
- ins_valid  output  1  queue head valid.
- ins_data  output  DATA_W  instruction at queue head.
- ins_pc  output  ADDR_W  PC of ins_data.
- ins_ready  input  1  decode accepts head.

Behaviour:
- Reset decision: clk clock; reset asynchronous, active-high.
- Reset values: fetch_pc = resp_pc = RESET_PC; queue count = 0; inflight = 0; drop_cnt = 0; mem_req = 0; mem_addr = RESET_PC; ins_valid = 0; ins_data = 0; ins_pc = 0.
- Request issue:
  - mem_req = !redirect_valid && (count + inflight) < DEPTH.
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc += 2 (mod 2^ADDR_W; 0xFFFE wraps to 0x0000) and inflight += 1.
  - mem_req and mem_addr are held until granted.
- Response:
  - On mem_rvalid: inflight -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {resp_pc, mem_rdata} and resp_pc += 2 (wraps).
  - The credit rule guarantees space; mem_rvalid with inflight == 0 is illegal (assertion).
- Output: ins_valid = (count != 0); ins_data and ins_pc come from the head entry, registered storage, stable while ins_valid && !ins_ready.
- Pop: ins_valid && ins_ready removes the head.
- Latency:
  - The word appears on ins_* the cycle after its mem_rvalid; no bypass.
  - With a zero-wait memory (gnt=1, rvalid 1 cycle after grant), the first ins_valid occurs 2 cycles after reset release.
  - Sustained throughput: 1 instruction/cycle.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Redirect cycle:
    - All queue entries are cleared; a head accepted by ins_ready in the same cycle counts as delivered.
    - fetch_pc = resp_pc = {redirect_addr[ADDR_W-1:1], 1'b0}.
    - drop_cnt_next = inflight_next (every remaining outstanding response is stale).
    - A response arriving in the redirect cycle is discarded regardless of drop_cnt.
    - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop accounting remains exact.
- Full/empty:
  - Issue stalls when count + inflight == DEPTH.
  - An empty queue holds ins_valid low; ins_data and ins_pc are don't-care but hold their last value.
- Reset mid-operation: all state clears immediately. Instruction memory shares the same reset, so no pre-reset responses arrive afterwards.
- Counter widths: count and inflight use clog2(DEPTH)+1 bits; drop_cnt is the same width.

Test Plan:
- Reset release, zero-wait memory returning rdata = addr ^ 16'hA5A5, ins_ready = 1 -> ins_pc sequence 0x0000, 0x0002, 0x0004 … with ins_valid first high 2 cycles after release, then one instruction per cycle.
- ins_ready = 0 for 10 cycles -> exactly DEPTH (4) grants, then mem_req = 0. Raise ins_ready -> PCs 0x0000..0x0006 delivered in order, then fetching resumes at 0x0008.
- Memory latency 3 cycles with 2 requests in flight; redirect to 0x0100 -> both stale responses dropped, queue empty, next ins_pc = 0x0100, no pre-redirect PC ever seen after the redirect cycle.
- Redirect with redirect_addr = 0x0203 while head accepted in the same cycle -> accepted head delivered once; next fetch address 0x0202.
- Redirect to 0xFFFC -> ins_pc sequence 0xFFFC, 0xFFFE, 0x0000.
- Assert reset for one cycle mid-stream with a full queue -> ins_valid = 0, mem_req = 0 immediately; after release, fetch restarts at RESET_PC.
